// File: rtl/alu_pkg.sv
// Shared constants for the ALU sharing controller: widths, salu opcodes and FSM state encoding.
package alu_pkg;
  localparam int DATA_W = 16;
  localparam int OP_W   = 4;
  localparam int FLAG_W = 4;

  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_SLL = 4'b1000;
  localparam logic [3:0] ALU_SLR = 4'b1001;
  localparam logic [3:0] ALU_SRL = 4'b1010;
  localparam logic [3:0] ALU_SRA = 4'b1011;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;
endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: on a tie the requester that did not win last time is granted.
module rr_arb2 (
  input  logic [1:0] valid,
  input  logic       last_owner,
  output logic       grant,
  output logic       any
);
  // grant selection; with a single valid the lone requester wins
  always_comb begin
    grant = 1'b0;
    if (valid == 2'b11) begin
      grant = ~last_owner;
    end else begin
      grant = valid[1];
    end
  end

  assign any = |valid;
endmodule

// File: rtl/alu_share_ctrl.sv
// Sequences two requesters onto one shared combinational ALU: accept, execute one cycle, hold the result.
module alu_share_ctrl
  import alu_pkg::*;
#(
  parameter int DATA_W = alu_pkg::DATA_W,
  parameter int OP_W   = alu_pkg::OP_W,
  parameter int FLAG_W = alu_pkg::FLAG_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [OP_W-1:0]   req0_op,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  output logic              resp0_valid,
  input  logic              resp0_ready,
  output logic [DATA_W-1:0] resp0_data,
  output logic [FLAG_W-1:0] resp0_flags,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [OP_W-1:0]   req1_op,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  output logic              resp1_valid,
  input  logic              resp1_ready,
  output logic [DATA_W-1:0] resp1_data,
  output logic [FLAG_W-1:0] resp1_flags,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [OP_W-1:0]   alu_salu,
  input  logic [DATA_W-1:0] alu_aout,
  input  logic [FLAG_W-1:0] alu_fout
);
  state_e            state_q, state_d;
  logic              owner_q, owner_d;
  logic              last_owner_q, last_owner_d;
  logic [DATA_W-1:0] alu_a_q, alu_a_d;
  logic [DATA_W-1:0] alu_b_q, alu_b_d;
  logic [OP_W-1:0]   alu_salu_q, alu_salu_d;
  logic [DATA_W-1:0] res_q, res_d;
  logic [FLAG_W-1:0] flg_q, flg_d;
  logic              resp0_valid_q, resp0_valid_d;
  logic              resp1_valid_q, resp1_valid_d;
  logic              grant_s, any_s, idle_s;

  rr_arb2 u_arb (
    .valid      ({req1_valid, req0_valid}),
    .last_owner (last_owner_q),
    .grant      (grant_s),
    .any        (any_s)
  );

  assign idle_s     = (state_q == ST_IDLE) & ~rst;
  assign req0_ready = idle_s & any_s & ~grant_s;
  assign req1_ready = idle_s & any_s & grant_s;

  // next-state and datapath register updates
  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    last_owner_d  = last_owner_q;
    alu_a_d       = alu_a_q;
    alu_b_d       = alu_b_q;
    alu_salu_d    = alu_salu_q;
    res_d         = res_q;
    flg_d         = flg_q;
    resp0_valid_d = resp0_valid_q;
    resp1_valid_d = resp1_valid_q;
    case (state_q)
      ST_IDLE: begin
        if (any_s) begin
          state_d      = ST_EXEC;
          owner_d      = grant_s;
          last_owner_d = grant_s;
          alu_a_d      = grant_s ? req1_a  : req0_a;
          alu_b_d      = grant_s ? req1_b  : req0_b;
          alu_salu_d   = grant_s ? req1_op : req0_op;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_EXEC: begin
        res_d         = alu_aout;
        flg_d         = alu_fout;
        resp0_valid_d = ~owner_q;
        resp1_valid_d = owner_q;
        state_d       = ST_RESP;
      end
      ST_RESP: begin
        if ((resp0_valid_q & resp0_ready) | (resp1_valid_q & resp1_ready)) begin
          resp0_valid_d = 1'b0;
          resp1_valid_d = 1'b0;
          state_d       = ST_IDLE;
        end else begin
          state_d = ST_RESP;
        end
      end
      default: begin
        resp0_valid_d = 1'b0;
        resp1_valid_d = 1'b0;
        state_d       = ST_IDLE;
      end
    endcase
  end

  // state registers; reset discards any in-flight transaction
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      owner_q       <= 1'b0;
      last_owner_q  <= 1'b1;
      alu_a_q       <= '0;
      alu_b_q       <= '0;
      alu_salu_q    <= '0;
      res_q         <= '0;
      flg_q         <= '0;
      resp0_valid_q <= 1'b0;
      resp1_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      owner_q       <= owner_d;
      last_owner_q  <= last_owner_d;
      alu_a_q       <= alu_a_d;
      alu_b_q       <= alu_b_d;
      alu_salu_q    <= alu_salu_d;
      res_q         <= res_d;
      flg_q         <= flg_d;
      resp0_valid_q <= resp0_valid_d;
      resp1_valid_q <= resp1_valid_d;
    end
  end

  assign alu_a       = alu_a_q;
  assign alu_b       = alu_b_q;
  assign alu_salu    = alu_salu_q;
  assign resp0_valid = resp0_valid_q;
  assign resp1_valid = resp1_valid_q;
  assign resp0_data  = res_q;
  assign resp1_data  = res_q;
  assign resp0_flags = flg_q;
  assign resp1_flags = flg_q;
endmodule
